// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing defaults for the block-graphics VGA reader.
package vga_pkg;

  // Phase of one scan axis; the same encoding is used for lines and for frames.
  typedef enum logic [1:0] {ACT, FP, SYNC, BP} h_state_t;

  // Width of the block coordinates and of the axis counters.
  localparam int unsigned COORD_W      = 10;

  // Default 640x480@60 timing, 50 MHz system clock.
  localparam int unsigned CLK_DIV_DEF  = 2;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned BLOCK_PX_DEF = 20;

  // pixelPacking field layout: [2:0]=R, [5:3]=G, [7:6]=B.
  localparam int unsigned R_W   = 3;
  localparam int unsigned R_OFF = 0;
  localparam int unsigned G_W   = 3;
  localparam int unsigned G_OFF = 3;
  localparam int unsigned B_W   = 2;
  localparam int unsigned B_OFF = 6;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: ACT/FP/SYNC/BP phase FSM, per-phase counter and block coordinate.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACT_LEN  = H_ACTIVE_DEF,
  parameter int unsigned FP_LEN   = H_FP_DEF,
  parameter int unsigned SYNC_LEN = H_SYNC_DEF,
  parameter int unsigned BP_LEN   = H_BP_DEF,
  parameter int unsigned BLK_LEN  = BLOCK_PX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               adv,
  output logic [COORD_W-1:0] blk,
  output logic               active,
  output logic               in_sync,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] L_ACT  = COORD_W'(ACT_LEN - 1);
  localparam logic [COORD_W-1:0] L_FP   = COORD_W'(FP_LEN - 1);
  localparam logic [COORD_W-1:0] L_SYNC = COORD_W'(SYNC_LEN - 1);
  localparam logic [COORD_W-1:0] L_BP   = COORD_W'(BP_LEN - 1);
  localparam logic [COORD_W-1:0] L_BLK  = COORD_W'(BLK_LEN - 1);

  h_state_t           state, state_nxt, phase_nxt;
  logic [COORD_W-1:0] cnt, cnt_nxt;
  logic [COORD_W-1:0] sub, sub_nxt;
  logic [COORD_W-1:0] blk_nxt;
  logic [COORD_W-1:0] last_cnt;
  logic               at_last;

  // State, phase counter and block counters update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACT;
      cnt   <= '0;
      sub   <= '0;
      blk   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sub   <= sub_nxt;
      blk   <= blk_nxt;
    end
  end

  // Next phase, counter reload and block stepping on each advance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sub_nxt   = sub;
    blk_nxt   = blk;
    phase_nxt = ACT;
    last_cnt  = L_ACT;
    unique case (state)
      ACT:  begin last_cnt = L_ACT;  phase_nxt = FP;   end
      FP:   begin last_cnt = L_FP;   phase_nxt = SYNC; end
      SYNC: begin last_cnt = L_SYNC; phase_nxt = BP;   end
      BP:   begin last_cnt = L_BP;   phase_nxt = ACT;  end
    endcase
    at_last = (cnt == last_cnt);
    wrap    = adv && (state == BP) && at_last;
    if (adv) begin
      if (at_last) begin
        state_nxt = phase_nxt;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      // Not stepping on the last active count keeps the final block
      // coordinate on display through blanking instead of running one past.
      if ((state == ACT) && !at_last) begin
        if (sub == L_BLK) begin
          sub_nxt = '0;
          blk_nxt = blk + 1'b1;
        end else begin
          sub_nxt = sub + 1'b1;
        end
      end
      if (wrap) begin
        sub_nxt = '0;
        blk_nxt = '0;
      end
    end
  end

  assign active  = (state == ACT);
  assign in_sync = (state == SYNC);

endmodule

// File: rtl/vga_block_scanner.sv
// VGA timing plus block-coordinate scanner feeding a combinational colour lookup.
module vga_block_scanner
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned BLOCK_PX = BLOCK_PX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x_coord_of_current_block,
  output logic [COORD_W-1:0] y_coord_of_current_block,
  input  logic [7:0]         pixelPacking,
  output logic               whichRAM,
  output logic               frame_start,
  output logic [R_W-1:0]     vga_r,
  output logic [G_W-1:0]     vga_g,
  output logic [B_W-1:0]     vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             pe;
  logic             eol;
  logic             frame_wrap;
  logic             h_act, v_act;
  logic             h_sync_st, v_sync_st;

  // Pixel-enable divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (pe) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pe = (div == DIV_LAST);

  vga_axis_counter #(
    .ACT_LEN (H_ACTIVE),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP),
    .BLK_LEN (BLOCK_PX)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .adv    (pe),
    .blk    (x_coord_of_current_block),
    .active (h_act),
    .in_sync(h_sync_st),
    .wrap   (eol)
  );

  vga_axis_counter #(
    .ACT_LEN (V_ACTIVE),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP),
    .BLK_LEN (BLOCK_PX)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .adv    (eol),
    .blk    (y_coord_of_current_block),
    .active (v_act),
    .in_sync(v_sync_st),
    .wrap   (frame_wrap)
  );

  // Colour and syncs share one pixel-wide pipeline stage so they stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else if (pe) begin
      if (h_act && v_act) begin
        vga_r <= pixelPacking[R_OFF +: R_W];
        vga_g <= pixelPacking[G_OFF +: G_W];
        vga_b <= pixelPacking[B_OFF +: B_W];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
      vga_hsync <= !h_sync_st;
      vga_vsync <= !v_sync_st;
    end
  end

  // Frame-start pulse and RAM-select toggle on the pe that wraps to line 0, pixel 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      whichRAM    <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      whichRAM    <= whichRAM ^ frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_block_scanner.sv
// Scoreboard bench for vga_block_scanner on a scaled-down timing set.
module tb_vga_block_scanner;

  localparam int unsigned CD   = 2;
  localparam int unsigned HA   = 40;
  localparam int unsigned HFP  = 4;
  localparam int unsigned HS   = 6;
  localparam int unsigned HB   = 6;
  localparam int unsigned HT   = HA + HFP + HS + HB;
  localparam int unsigned VA   = 40;
  localparam int unsigned VFP  = 2;
  localparam int unsigned VS   = 2;
  localparam int unsigned VB   = 4;
  localparam int unsigned VT   = VA + VFP + VS + VB;
  localparam int unsigned BK   = 4;
  localparam int unsigned NPIX = HT * VT;
  localparam int unsigned FCLK = CD * NPIX;

  typedef struct {
    int unsigned r;
    int unsigned g;
    int unsigned b;
    int unsigned hs;
    int unsigned vs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x_coord, y_coord;
  logic [7:0] pixelPacking;
  logic       whichRAM, frame_start, vga_hsync, vga_vsync;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic       pp_mode;

  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  // Graphics controller: combinational colour per block, or a fixed colour.
  assign pixelPacking = pp_mode ? 8'hE5 : {x_coord[4:0], y_coord[2:0]};

  vga_block_scanner #(
    .CLK_DIV (CD),
    .H_ACTIVE(HA),
    .H_FP    (HFP),
    .H_SYNC  (HS),
    .H_BP    (HB),
    .V_ACTIVE(VA),
    .V_FP    (VFP),
    .V_SYNC  (VS),
    .V_BP    (VB),
    .BLOCK_PX(BK)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .x_coord_of_current_block(x_coord),
    .y_coord_of_current_block(y_coord),
    .pixelPacking            (pixelPacking),
    .whichRAM                (whichRAM),
    .frame_start             (frame_start),
    .vga_r                   (vga_r),
    .vga_g                   (vga_g),
    .vga_b                   (vga_b),
    .vga_hsync               (vga_hsync),
    .vga_vsync               (vga_vsync)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Compare DUT state after `cyc` clock edges since reset release against the model.
  task automatic check_cycle();
    int unsigned p, hp, vl, ex, ey;
    logic [7:0]  pp;
    logic [7:0]  exv, eyv;
    logic        act;
    exp_t        e;
    p  = cyc / CD;
    hp = p % HT;
    vl = (p / HT) % VT;
    ex = (hp < HA) ? hp / BK : HA / BK - 1;
    ey = (vl < VA) ? vl / BK : VA / BK - 1;
    check_eq("frame_start", frame_start, (cyc > 0 && (cyc % FCLK) == 0) ? 1 : 0);
    check_eq("whichRAM", whichRAM, (cyc / FCLK) % 2);
    if ((cyc % CD) == CD - 1) begin
      check_eq("x_coord", x_coord, ex);
      check_eq("y_coord", y_coord, ey);
      exv  = 8'(ex);
      eyv  = 8'(ey);
      pp   = pp_mode ? 8'hE5 : {exv[4:0], eyv[2:0]};
      act  = (hp < HA) && (vl < VA);
      e.r  = act ? pp[2:0] : 0;
      e.g  = act ? pp[5:3] : 0;
      e.b  = act ? pp[7:6] : 0;
      e.hs = (hp >= HA + HFP && hp < HA + HFP + HS) ? 0 : 1;
      e.vs = (vl >= VA + VFP && vl < VA + VFP + VS) ? 0 : 1;
      sb.push_back(e);
    end
    if ((cyc % CD) == 0 && cyc > 0) begin
      if (sb.size() == 0) begin
        check_eq("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        check_eq("vga_r", vga_r, e.r);
        check_eq("vga_g", vga_g, e.g);
        check_eq("vga_b", vga_b, e.b);
        check_eq("vga_hsync", vga_hsync, e.hs);
        check_eq("vga_vsync", vga_vsync, e.vs);
      end
    end
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x"}, x_coord, 0);
    check_eq({tag, "_y"}, y_coord, 0);
    check_eq({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check_eq({tag, "_hsync"}, vga_hsync, 1);
    check_eq({tag, "_vsync"}, vga_vsync, 1);
    check_eq({tag, "_whichRAM"}, whichRAM, 0);
    check_eq({tag, "_frame_start"}, frame_start, 0);
  endtask

  initial begin
    logic found;
    reset   = 1'b0;
    pp_mode = 1'b0;
    cyc     = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Release, then a frame of block-derived colour and a few lines of the next.
    reset = 1'b1;
    cyc   = 0;
    check_cycle();
    run_cycles(FCLK + 2 * CD * HT);

    // Constant colour 8'hE5 across a full frame, including blanking.
    pp_mode = 1'b1;
    run_cycles(FCLK);
    pp_mode = 1'b0;

    // Advance to line 30, pixel 20 and hit reset asynchronously mid-cycle.
    found = 1'b0;
    for (int unsigned i = 0; i < 2 * FCLK && !found; i++) begin
      run_cycles(1);
      if ((cyc % CD) == CD - 1 && ((cyc / CD) % HT) == 20 && ((cyc / CD / HT) % VT) == 30)
        found = 1'b1;
    end
    check_eq("seek_timeout", found, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");

    // Timing restarts from line 0, pixel 0.
    reset = 1'b1;
    cyc   = 0;
    check_cycle();
    run_cycles(FCLK + 2 * CD * HT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
